// File: rtl/verin_pos_ctrl.sv
// Closed-loop verin position controller: ADC0831-style serial sampler, IDLE/MOVING
// deadband FSM and a direction-safe PWM stage behind a 4-register Avalon-MM slave.
module verin_pos_ctrl #(
    parameter int ADC_DIV    = 50,
    parameter int PWM_PERIOD = 2000,
    parameter int DEADBAND   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        adc_cs_n,
    output logic        adc_clk,
    input  logic        adc_data,
    output logic        out_pwm,
    output logic        out_sens
);
    localparam int              DIVW     = $clog2(ADC_DIV + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(ADC_DIV - 1);
    localparam logic [11:0]     PWM_LAST = 12'(PWM_PERIOD - 1);
    localparam logic [11:0]     PWM_FULL = 12'(PWM_PERIOD);
    localparam logic [8:0]      DB       = 9'(DEADBAND);

    typedef enum logic {ST_IDLE = 1'b0, ST_MOVING = 1'b1} state_t;

    logic            r_enable;
    logic [7:0]      r_target;
    logic [10:0]     r_duty;
    logic            r_sync1, r_sync2;
    logic            r_run;
    logic [DIVW-1:0] r_div;
    logic [4:0]      r_half;
    logic [7:0]      r_shift;
    logic [7:0]      r_sample;
    logic            r_sample_valid;
    state_t          r_state;
    logic            r_done;
    logic [7:0]      r_tgt;
    logic            r_dir_req;
    logic            r_dir_valid;
    logic [11:0]     r_cnt;
    logic [11:0]     r_duty_lat;
    logic            r_armed;

    logic            w_wr_ctrl, w_go, w_abort, w_disable;
    logic [DIVW-1:0] w_div_nxt;
    logic [4:0]      w_half_nxt;
    logic            w_adc_step, w_frame_act, w_capture, w_frame_done;
    logic [8:0]      w_diff;
    state_t          w_state_nxt;
    logic            w_done_nxt, w_dir_req_nxt, w_dir_valid_nxt;
    logic [7:0]      w_tgt_nxt;
    logic [11:0]     w_cnt_nxt, w_duty_eff, w_duty_lat_nxt;
    logic            w_wrap, w_armed_nxt, w_sens_nxt, w_pwm_nxt;
    logic [31:0]     w_rdata;
    logic            w_unused_wdata;

    assign w_wr_ctrl      = avs_write && (avs_address == 2'd0);
    assign w_abort        = w_wr_ctrl && avs_writedata[2];
    // GO needs ENABLE in the same write; ABORT in that write suppresses it.
    assign w_go           = w_wr_ctrl && avs_writedata[1] && avs_writedata[0] && !avs_writedata[2];
    assign w_disable      = w_wr_ctrl && !avs_writedata[0];
    assign w_unused_wdata = &{1'b0, avs_writedata[31:11]};

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_target <= 8'd0;
            r_duty   <= 11'd0;
        end else begin
            if (w_wr_ctrl) r_enable <= avs_writedata[0];
            if (avs_write && (avs_address == 2'd1)) r_target <= avs_writedata[7:0];
            if (avs_write && (avs_address == 2'd2)) r_duty <= avs_writedata[10:0];
        end
    end

    // Frame position: 20 half-periods of ADC_DIV cycles; halves 0..17 clocked, 18..19 deselected.
    always_comb begin
        w_div_nxt  = '0;
        w_half_nxt = 5'd0;
        w_adc_step = 1'b0;
        if (r_enable && r_run) begin
            if (r_div == DIV_LAST) begin
                w_adc_step = 1'b1;
                w_half_nxt = (r_half == 5'd19) ? 5'd0 : r_half + 5'd1;
            end else begin
                w_div_nxt  = r_div + 1'b1;
                w_half_nxt = r_half;
            end
        end else begin
            w_adc_step = 1'b0;
        end
    end

    assign w_frame_act  = r_enable && (w_half_nxt < 5'd18);
    assign w_capture    = w_adc_step && w_half_nxt[0] && (w_half_nxt >= 5'd3) && (w_half_nxt <= 5'd17);
    assign w_frame_done = w_adc_step && (w_half_nxt == 5'd18);

    // ADC sequencer, data synchroniser and sample capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_run          <= 1'b0;
            r_div          <= '0;
            r_half         <= 5'd0;
            r_shift        <= 8'd0;
            r_sample       <= 8'd0;
            r_sample_valid <= 1'b0;
            adc_cs_n       <= 1'b1;
            adc_clk        <= 1'b0;
        end else begin
            r_sync1        <= adc_data;
            r_sync2        <= r_sync1;
            r_run          <= r_enable;
            r_div          <= w_div_nxt;
            r_half         <= w_half_nxt;
            adc_cs_n       <= !w_frame_act;
            adc_clk        <= w_frame_act && w_half_nxt[0];
            r_sample_valid <= w_frame_done;
            if (w_capture) r_shift <= {r_shift[6:0], r_sync2};
            if (w_frame_done) r_sample <= r_shift;
        end
    end

    // 9-bit magnitude so positions near 0x00/0xFF never wrap.
    always_comb begin
        if (r_sample >= r_tgt) begin
            w_diff = {1'b0, r_sample} - {1'b0, r_tgt};
        end else begin
            w_diff = {1'b0, r_tgt} - {1'b0, r_sample};
        end
    end

    // Control FSM next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = r_done;
        w_tgt_nxt       = r_tgt;
        w_dir_req_nxt   = r_dir_req;
        w_dir_valid_nxt = r_dir_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_abort) begin
                    w_done_nxt = 1'b0;
                end else if (w_go) begin
                    w_state_nxt     = ST_MOVING;
                    w_tgt_nxt       = r_target;
                    w_done_nxt      = 1'b0;
                    w_dir_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVING: begin
                if (w_abort || w_disable || !r_enable) begin
                    w_state_nxt     = ST_IDLE;
                    w_done_nxt      = 1'b0;
                    w_dir_valid_nxt = 1'b0;
                end else if (r_sample_valid) begin
                    if (w_diff <= DB) begin
                        w_state_nxt     = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_dir_valid_nxt = 1'b0;
                    end else begin
                        w_dir_req_nxt   = (r_tgt > r_sample);
                        w_dir_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_MOVING;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_done_nxt      = 1'b0;
                w_dir_valid_nxt = 1'b0;
            end
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b0;
            r_tgt       <= 8'd0;
            r_dir_req   <= 1'b0;
            r_dir_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_tgt       <= w_tgt_nxt;
            r_dir_req   <= w_dir_req_nxt;
            r_dir_valid <= w_dir_valid_nxt;
        end
    end

    // Duty and direction only change at a period boundary, so no pulse is cut or reversed.
    always_comb begin
        w_cnt_nxt      = (r_cnt == PWM_LAST) ? 12'd0 : r_cnt + 12'd1;
        w_wrap         = (w_cnt_nxt == 12'd0);
        w_duty_eff     = ({1'b0, r_duty} > PWM_FULL) ? PWM_FULL : {1'b0, r_duty};
        w_duty_lat_nxt = w_wrap ? w_duty_eff : r_duty_lat;
        w_sens_nxt     = out_sens;
        if (w_state_nxt != ST_MOVING) begin
            w_armed_nxt = 1'b0;
        end else if (w_wrap && w_dir_valid_nxt) begin
            w_armed_nxt = 1'b1;
            w_sens_nxt  = w_dir_req_nxt;
        end else begin
            w_armed_nxt = r_armed;
        end
        w_pwm_nxt = (w_state_nxt == ST_MOVING) && w_armed_nxt && (w_cnt_nxt < w_duty_lat_nxt);
    end

    // PWM counter and power-stage outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 12'd0;
            r_duty_lat <= 12'd0;
            r_armed    <= 1'b0;
            out_sens   <= 1'b0;
            out_pwm    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_duty_lat <= w_duty_lat_nxt;
            r_armed    <= w_armed_nxt;
            out_sens   <= w_sens_nxt;
            out_pwm    <= w_pwm_nxt;
        end
    end

    // Read mux; CTRL reads back only ENABLE.
    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            2'd0:    w_rdata = {31'd0, r_enable};
            2'd1:    w_rdata = {24'd0, r_target};
            2'd2:    w_rdata = {21'd0, r_duty};
            2'd3:    w_rdata = {22'd0, r_done, (r_state == ST_MOVING), r_sample};
            default: w_rdata = 32'd0;
        endcase
    end

    // Registered read data, one cycle after avs_read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            avs_readdata <= w_rdata;
        end else begin
            avs_readdata <= avs_readdata;
        end
    end

endmodule
